lsu_arbiter: RTL and testbench



---
 rtl/lsu_arbiter.sv | 126 ++++++++++++
 tb/tb_lsu_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one load/store unit port between the CPU data port (M0)
// and the debug/program-loader port (M1). M0 has fixed priority. An M1 wait
// counter forces an M1 grant once M1 has been pending for MAX_WAIT cycles.
// Each access runs IDLE -> ISSUE (-> RESP for loads) -> IDLE. The LSU port is
// parked on an unmapped address outside ISSUE.
module lsu_arbiter #(
    parameter int unsigned MAX_WAIT  = 8,
    parameter logic [31:0] PARK_ADDR = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m0_req,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_strb,
    input  logic        i_m0_wren,
    input  logic        i_m1_req,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_strb,
    input  logic        i_m1_wren,
    output logic        o_m0_gnt,
    output logic        o_m0_rvld,
    output logic [31:0] o_m0_rdata,
    output logic        o_m0_err,
    output logic        o_m1_gnt,
    output logic        o_m1_rvld,
    output logic [31:0] o_m1_rdata,
    output logic        o_m1_err,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_st_data,
    output logic [3:0]  o_st_strb,
    output logic        o_lsu_wren,
    input  logic [31:0] i_ld_data,
    input  logic        i_data_vld
);

    typedef enum logic [1:0] { ST_IDLE, ST_ISSUE, ST_RESP } state_t;

    state_t     state;
    logic       owner;      // 1 while M1 owns the access in flight
    logic [7:0] m1_wait;    // consecutive cycles M1 has been pending ungranted

    logic any_req;
    logic pick_m1;
    logic m1_latch;

    // Arbitration decision, meaningful only while the FSM sits in IDLE.
    always_comb begin
        any_req  = i_m0_req | i_m1_req;
        pick_m1  = (i_m1_req && (32'(m1_wait) >= MAX_WAIT)) || !i_m0_req;
        m1_latch = (state == ST_IDLE) && any_req && pick_m1;
    end

    // Access sequencer: latches the winner and registers every LSU-side and pulse output.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            o_m0_gnt   <= 1'b0;
            o_m1_gnt   <= 1'b0;
            o_m0_rvld  <= 1'b0;
            o_m1_rvld  <= 1'b0;
            o_lsu_addr <= PARK_ADDR;
            o_st_data  <= '0;
            o_st_strb  <= '0;
            o_lsu_wren <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the reads of o_lsu_wren and
            // owner below see this cycle's values even though the defaults re-park them.
            o_m0_gnt   <= 1'b0;
            o_m1_gnt   <= 1'b0;
            o_m0_rvld  <= 1'b0;
            o_m1_rvld  <= 1'b0;
            o_lsu_addr <= PARK_ADDR;
            o_st_data  <= '0;
            o_st_strb  <= '0;
            o_lsu_wren <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state      <= ST_ISSUE;
                        owner      <= pick_m1;
                        o_m0_gnt   <= !pick_m1;
                        o_m1_gnt   <= pick_m1;
                        o_lsu_addr <= pick_m1 ? i_m1_addr  : i_m0_addr;
                        o_st_data  <= pick_m1 ? i_m1_wdata : i_m0_wdata;
                        o_st_strb  <= pick_m1 ? i_m1_strb  : i_m0_strb;
                        o_lsu_wren <= pick_m1 ? i_m1_wren  : i_m0_wren;
                    end
                end
                ST_ISSUE: begin
                    // Stores finish here; loads wait one cycle for the LSU data.
                    state     <= o_lsu_wren ? ST_IDLE : ST_RESP;
                    o_m0_rvld <= !owner && !o_lsu_wren;
                    o_m1_rvld <= owner && !o_lsu_wren;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // M1 starvation counter: saturating, cleared when M1 wins arbitration.
    always_ff @(posedge i_clk) begin
        if (i_rst || m1_latch) begin
            m1_wait <= '0;
        end else if (i_m1_req && (m1_wait != 8'hFF)) begin
            m1_wait <= m1_wait + 8'd1;
        end
    end

    // Response data path: data is only ever seen by the master whose rvld pulses.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        o_m0_err   = o_m0_rvld & ~i_data_vld;
        o_m1_err   = o_m1_rvld & ~i_data_vld;
        o_m0_rdata = (o_m0_rvld && i_data_vld) ? i_ld_data : '0;
        o_m1_rdata = (o_m1_rvld && i_data_vld) ? i_ld_data : '0;
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed scenarios followed by randomized traffic. A memory
// model plays the LSU (RAM at 0x0000-0x3FFF, LEDR at 0x7000, all else
// unmapped). A transaction-level reference model schedules the expected
// outputs for every cycle from each arbitration decision.
module tb_lsu_arbiter;

    localparam int          MAX_WAIT = 8;
    localparam logic [31:0] PARK     = 32'hFFFF_FFFF;
    localparam int          NCYC     = 4000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_m0_req, i_m1_req;
    logic [31:0] i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata;
    logic [3:0]  i_m0_strb, i_m1_strb;
    logic        i_m0_wren, i_m1_wren;
    logic        o_m0_gnt, o_m1_gnt, o_m0_rvld, o_m1_rvld, o_m0_err, o_m1_err;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic [31:0] o_lsu_addr, o_st_data;
    logic [3:0]  o_st_strb;
    logic        o_lsu_wren;
    logic [31:0] i_ld_data;
    logic        i_data_vld;

    lsu_arbiter #(.MAX_WAIT(MAX_WAIT), .PARK_ADDR(PARK)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_addr(i_m0_addr), .i_m0_wdata(i_m0_wdata),
        .i_m0_strb(i_m0_strb), .i_m0_wren(i_m0_wren),
        .i_m1_req(i_m1_req), .i_m1_addr(i_m1_addr), .i_m1_wdata(i_m1_wdata),
        .i_m1_strb(i_m1_strb), .i_m1_wren(i_m1_wren),
        .o_m0_gnt(o_m0_gnt), .o_m0_rvld(o_m0_rvld), .o_m0_rdata(o_m0_rdata), .o_m0_err(o_m0_err),
        .o_m1_gnt(o_m1_gnt), .o_m1_rvld(o_m1_rvld), .o_m1_rdata(o_m1_rdata), .o_m1_err(o_m1_err),
        .o_lsu_addr(o_lsu_addr), .o_st_data(o_st_data), .o_st_strb(o_st_strb),
        .o_lsu_wren(o_lsu_wren), .i_ld_data(i_ld_data), .i_data_vld(i_data_vld)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wren;
    } acc_t;

    typedef struct packed {
        logic        g0, g1, r0, r1, err;
        logic [31:0] rdata, addr, sdata;
        logic [3:0]  strb;
        logic        wren;
    } cyc_exp_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    cyc_exp_t    exp_q [NCYC + 8];
    logic [31:0] mem [4096];      // LSU-side memory
    logic [31:0] ledr;
    logic [31:0] ref_mem [4096];  // reference-model view of memory
    logic [31:0] ref_ledr;
    int          free_at;         // first edge at which the arbiter may take a request
    int          m1_pend;         // edges M1 has been pending since it last won
    acc_t        q0[$], q1[$];
    bit          gappy    = 0;
    bit          stray_en = 0;

    // Scenario observation
    int          m1_lat = 0;
    bit          lat_chk = 0, starve = 0, m1_done = 0, track_first = 0, first_owner = 0;
    int          m0_after = 0, rv0_cnt = 0, rv1_cnt = 0;
    logic [31:0] last_rd0, last_rd1;
    logic        last_err0, last_err1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic cyc_exp_t park_exp();
        cyc_exp_t x;
        x = '0;
        x.addr = PARK;
        return x;
    endfunction

    // LSU model: commits stores at the edge, returns load data one cycle after the address.
    logic [31:0] env_addr, env_wdata;
    logic [3:0]  env_strb;
    logic        env_we;
    always @(posedge i_clk) begin
        env_addr  = o_lsu_addr;
        env_we    = o_lsu_wren;
        env_strb  = o_st_strb;
        env_wdata = o_st_data;
        if (env_we === 1'b1) begin
            if (env_addr < 32'h4000) mem[env_addr[13:2]] = merge(mem[env_addr[13:2]], env_wdata, env_strb);
            else if (env_addr == 32'h7000) ledr = merge(ledr, env_wdata, env_strb);
        end
        #1;
        if (env_we === 1'b0 && env_addr < 32'h4000) begin
            i_data_vld = 1'b1; i_ld_data = mem[env_addr[13:2]];
        end else if (env_we === 1'b0 && env_addr == 32'h7000) begin
            i_data_vld = 1'b1; i_ld_data = ledr;
        end else if (env_addr == PARK && stray_en && $urandom_range(3) == 0) begin
            i_data_vld = 1'b1; i_ld_data = $urandom;
        end else begin
            i_data_vld = 1'b0; i_ld_data = $urandom;
        end
    end

    function automatic bit ref_read(input logic [31:0] a, output logic [31:0] d);
        d = '0;
        if (a < 32'h4000) begin d = ref_mem[a[13:2]]; return 1; end
        if (a == 32'h7000) begin d = ref_ledr; return 1; end
        return 0;
    endfunction

    // Reference model, evaluated with the request lines as sampled at edge e.
    task automatic model_edge(input int e);
        bit r0, r1, win1, took, ok;
        acc_t a;
        cyc_exp_t x, y;
        logic [31:0] d;
        r0 = i_m0_req; r1 = i_m1_req;
        if (i_rst) begin
            exp_q[e] = park_exp(); exp_q[e+1] = park_exp();
            free_at = e + 1; m1_pend = 0; m1_lat = 0;
            return;
        end
        if (r1) m1_lat++;
        took = 0; win1 = 0;
        if (e >= free_at && (r0 || r1)) begin
            win1 = (r1 && m1_pend >= MAX_WAIT) || !r0;
            a = win1 ? acc_t'{i_m1_addr, i_m1_wdata, i_m1_strb, i_m1_wren}
                     : acc_t'{i_m0_addr, i_m0_wdata, i_m0_strb, i_m0_wren};
            x = park_exp();
            x.g0 = !win1; x.g1 = win1;
            x.addr = a.addr; x.sdata = a.wdata; x.strb = a.strb; x.wren = a.wren;
            exp_q[e] = x;
            if (a.wren) begin
                if (a.addr < 32'h4000) ref_mem[a.addr[13:2]] = merge(ref_mem[a.addr[13:2]], a.wdata, a.strb);
                else if (a.addr == 32'h7000) ref_ledr = merge(ref_ledr, a.wdata, a.strb);
                free_at = e + 2;
            end else begin
                y = park_exp();
                y.r0 = !win1; y.r1 = win1;
                ok = ref_read(a.addr, d);
                y.err = !ok; y.rdata = ok ? d : 32'h0;
                exp_q[e+1] = y;
                free_at = e + 3;
            end
            took = 1;
        end
        if (took && win1) m1_pend = 0;
        else if (r1 && m1_pend < 255) m1_pend++;
    endtask

    task automatic present(input int m, input acc_t a);
        if (m == 0) begin
            i_m0_req = 1'b1; i_m0_addr = a.addr; i_m0_wdata = a.wdata; i_m0_strb = a.strb; i_m0_wren = a.wren;
        end else begin
            i_m1_req = 1'b1; i_m1_addr = a.addr; i_m1_wdata = a.wdata; i_m1_strb = a.strb; i_m1_wren = a.wren;
        end
    endtask

    task automatic drive_masters();
        if (o_m0_gnt) begin q0.delete(0); i_m0_req = 1'b0; end
        if (o_m1_gnt) begin q1.delete(0); i_m1_req = 1'b0; end
        if (!i_m0_req && q0.size() > 0 && (!gappy || $urandom_range(2) != 0)) present(0, q0[0]);
        if (!i_m1_req && q1.size() > 0 && (!gappy || $urandom_range(2) != 0)) present(1, q1[0]);
    endtask

    task automatic check_cycle(input int k);
        cyc_exp_t x;
        x = exp_q[k];
        check("m0_gnt",   o_m0_gnt,   x.g0);
        check("m1_gnt",   o_m1_gnt,   x.g1);
        check("no_overlap", o_m0_gnt & o_m1_gnt, 0);
        check("m0_rvld",  o_m0_rvld,  x.r0);
        check("m1_rvld",  o_m1_rvld,  x.r1);
        check("m0_err",   o_m0_err,   x.r0 & x.err);
        check("m1_err",   o_m1_err,   x.r1 & x.err);
        check("m0_rdata", o_m0_rdata, x.r0 ? x.rdata : 32'h0);
        check("m1_rdata", o_m1_rdata, x.r1 ? x.rdata : 32'h0);
        check("lsu_addr", o_lsu_addr, x.addr);
        check("lsu_wren", o_lsu_wren, x.wren);
        check("st_strb",  o_st_strb,  x.strb);
        check("st_data",  o_st_data,  x.sdata);
        if (o_m0_rvld) begin rv0_cnt++; last_rd0 = o_m0_rdata; last_err0 = o_m0_err; end
        if (o_m1_rvld) begin rv1_cnt++; last_rd1 = o_m1_rdata; last_err1 = o_m1_err; end
        if (track_first && (o_m0_gnt || o_m1_gnt)) begin first_owner = o_m1_gnt; track_first = 0; end
        if (starve && o_m0_gnt && m1_done) m0_after++;
        if (o_m1_gnt) begin
            if (lat_chk) check("m1_latency_bound", (m1_lat <= MAX_WAIT + 3) ? 1 : 0, 1);
            if (starve) m1_done = 1;
            m1_lat = 0;
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        cyc++;
        if (cyc >= NCYC) begin
            $display("FAIL cycle_budget: observed %0d cycles, limit %0d", cyc, NCYC);
            $fatal(1, "cycle budget exhausted");
        end
        model_edge(cyc);
        #1;
        drive_masters();
        @(negedge i_clk);
        check_cycle(cyc);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && (q0.size() != 0 || q1.size() != 0 || cyc < free_at); i++) step();
        check(tag, q0.size() + q1.size(), 0);
        step(); step();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    function automatic acc_t rand_acc();
        acc_t a;
        int   sel;
        sel = $urandom_range(9);
        if (sel < 6)      a.addr = 32'h2000 + 32'($urandom_range(7)) * 4;
        else if (sel < 8) a.addr = 32'h7000;
        else              a.addr = ($urandom_range(1) != 0) ? 32'h5000 : 32'h8000_0000;
        a.wdata = $urandom;
        a.strb  = 4'($urandom);
        a.wren  = 1'($urandom_range(1));
        return a;
    endfunction

    initial begin
        int snap;
        i_rst = 1'b1;
        i_m0_req = 0; i_m0_addr = 0; i_m0_wdata = 0; i_m0_strb = 0; i_m0_wren = 0;
        i_m1_req = 0; i_m1_addr = 0; i_m1_wdata = 0; i_m1_strb = 0; i_m1_wren = 0;
        i_ld_data = 0; i_data_vld = 0;
        for (int i = 0; i < 4096; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[12'h800] = 32'hDEAD_BEEF; ref_mem[12'h800] = 32'hDEAD_BEEF;
        ledr = '0; ref_ledr = '0;
        for (int i = 0; i < NCYC + 8; i++) exp_q[i] = park_exp();
        free_at = 0; m1_pend = 0;

        // Reset: two cycles held, outputs idle and LSU parked.
        step(); step();
        i_rst = 1'b0;
        step();

        // Single M0 load from preloaded RAM.
        q0.push_back(acc_t'{32'h2000, 32'h0, 4'h0, 1'b0});
        drain("t1_drain", 20);
        check("t1_rdata", last_rd0, 32'hDEAD_BEEF);
        check("t1_err", last_err0, 0);

        // M1 store to LEDR, then M1 load back.
        snap = rv1_cnt;
        q1.push_back(acc_t'{32'h7000, 32'h0000_00A5, 4'b0001, 1'b1});
        q1.push_back(acc_t'{32'h7000, 32'h0, 4'h0, 1'b0});
        drain("t2_drain", 20);
        check("t2_ledr", ledr, 32'h0000_00A5);
        check("t2_rdata", last_rd1, 32'h0000_00A5);
        check("t2_rvld_count", rv1_cnt - snap, 1);

        // M0 load from an unmapped address.
        q0.push_back(acc_t'{32'h5000, 32'h0, 4'h0, 1'b0});
        drain("t3_drain", 20);
        check("t3_err", last_err0, 1);
        check("t3_rdata", last_rd0, 32'h0);

        // Both request straight out of reset: M0 first, then M1.
        do_reset();
        track_first = 1;
        q0.push_back(acc_t'{32'h2004, 32'h0, 4'h0, 1'b0});
        q1.push_back(acc_t'{32'h2000, 32'h0, 4'h0, 1'b0});
        drain("t4_drain", 20);
        check("t4_first_is_m0", first_owner, 0);
        check("t4_m1_rdata", last_rd1, 32'hDEAD_BEEF);

        // Reset while an M0 load sits in ISSUE: no rvld, then a fresh M1 load.
        q0.push_back(acc_t'{32'h2000, 32'h0, 4'h0, 1'b0});
        for (int i = 0; i < 10 && !o_m0_gnt; i++) step();
        check("t5_gnt_seen", o_m0_gnt, 1);
        snap = rv0_cnt;
        do_reset();
        step(); step();
        check("t5_no_rvld", rv0_cnt - snap, 0);
        q1.push_back(acc_t'{32'h2000, 32'h0, 4'h0, 1'b0});
        drain("t5_drain", 20);
        check("t5_m1_rdata", last_rd1, 32'hDEAD_BEEF);

        // Continuous M0 loads with M1 holding req: bounded M1 wait, M0 resumes.
        m1_lat = 0; lat_chk = 1; starve = 1; m1_done = 0; m0_after = 0;
        for (int i = 0; i < 12; i++) q0.push_back(acc_t'{32'h2000 + 32'(i) * 4, 32'h0, 4'h0, 1'b0});
        step();
        q1.push_back(acc_t'{32'h7000, 32'h0, 4'h0, 1'b0});
        drain("t6_drain", 80);
        check("t6_m1_granted", m1_done, 1);
        check("t6_m0_resumes", (m0_after > 0) ? 1 : 0, 1);
        starve = 0; lat_chk = 0;

        // Randomized traffic with gaps and stray LSU data-valid pulses.
        gappy = 1; stray_en = 1;
        for (int i = 0; i < 120; i++) begin
            q0.push_back(rand_acc());
            q1.push_back(rand_acc());
        end
        drain("rand_drain", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
